rx_bit_sampler: RTL and testbench

UART-RX oversampling front end: counts prescaled clock edges within each bit period, takes three samples of the serial line around mid-bit, and produces a majority-voted bit with a one-cycle valid strobe. It sits between the RX line (already synchronised) and the RX checkers (start, parity, stop check) and deserializer. The RX FSM consumes its counters and strobes and enables it per frame.

---
 rtl/rx_bit_sampler.sv | 94 +++++++++
 tb/tb_rx_bit_sampler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_bit_sampler.sv
// UART-RX oversampling front end: tracks position within each bit period,
// takes three mid-bit samples of RX_IN and emits a majority-voted bit with a valid strobe.
module rx_bit_sampler #(
    parameter int FRAME_BITS = 11,
    parameter int CNT_W      = 6,
    parameter int BIT_W      = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RX_IN,
    input  logic [CNT_W-1:0] Prescale,
    input  logic             dat_samp_en,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [BIT_W-1:0] bit_cnt,
    output logic             bit_done,
    output logic             sampled_bit,
    output logic             sample_valid
);

    logic [CNT_W-1:0] p_eff;
    logic [CNT_W-1:0] p_reg;
    logic [CNT_W-1:0] half_p;
    logic             s0, s1, s2;
    logic             hit_s0, hit_s1, hit_s2, hit_decide;
    logic             edge_wrap;
    logic             last_bit;
    logic             vote;

    // Odd ratios round down to even and anything below 8 clamps to 8.
    always_comb begin
        p_eff = Prescale & ~CNT_W'(1);
        if (p_eff < CNT_W'(8)) begin
            p_eff = CNT_W'(8);
        end
    end

    always_comb begin
        half_p     = p_reg >> 1;
        hit_s0     = (edge_cnt == half_p - CNT_W'(2));
        hit_s1     = (edge_cnt == half_p - CNT_W'(1));
        hit_s2     = (edge_cnt == half_p);
        hit_decide = (edge_cnt == half_p + CNT_W'(1));
        edge_wrap  = (edge_cnt >= p_reg - CNT_W'(1));
        last_bit   = (bit_cnt == BIT_W'(FRAME_BITS - 1));
        vote       = (s0 & s1) | (s0 & s2) | (s1 & s2);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            p_reg        <= CNT_W'(8);
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            bit_done     <= 1'b0;
            sample_valid <= 1'b0;
            sampled_bit  <= 1'b1;
            s0           <= 1'b0;
            s1           <= 1'b0;
            s2           <= 1'b0;
        end else if (!dat_samp_en) begin
            // Idle: the ratio is only re-captured between frames, so a
            // mid-frame Prescale change cannot distort the running bit period.
            p_reg        <= p_eff;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            bit_done     <= 1'b0;
            sample_valid <= 1'b0;
            s0           <= 1'b0;
            s1           <= 1'b0;
            s2           <= 1'b0;
        end else begin
            bit_done     <= edge_wrap;
            sample_valid <= hit_decide;
            if (edge_wrap) begin
                edge_cnt <= '0;
                bit_cnt  <= last_bit ? '0 : bit_cnt + BIT_W'(1);
            end else begin
                edge_cnt <= edge_cnt + CNT_W'(1);
            end
            if (hit_s0) begin
                s0 <= RX_IN;
            end
            if (hit_s1) begin
                s1 <= RX_IN;
            end
            if (hit_s2) begin
                s2 <= RX_IN;
            end
            if (hit_decide) begin
                sampled_bit <= vote;
            end
        end
    end

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Bench for rx_bit_sampler: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a run-length/history model.
module tb_rx_bit_sampler;

    localparam int FRAME_BITS = 11;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       dat_samp_en = 1'b0;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       bit_done;
    logic       sampled_bit;
    logic       sample_valid;

    int total = 0;
    int bad = 0;

    rx_bit_sampler #(.FRAME_BITS(FRAME_BITS), .CNT_W(6), .BIT_W(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_IN(RX_IN),
        .Prescale(Prescale),
        .dat_samp_en(dat_samp_en),
        .edge_cnt(edge_cnt),
        .bit_cnt(bit_cnt),
        .bit_done(bit_done),
        .sampled_bit(sampled_bit),
        .sample_valid(sample_valid)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic x, input logic [5:0] p);
        @(negedge CLK);
        RST = r;
        dat_samp_en = e;
        RX_IN = x;
        Prescale = p;
    endtask

    function automatic int effP(input logic [5:0] ps);
        int v;
        v = int'(ps) - (int'(ps) % 2);
        if (v < 8) v = 8;
        return v;
    endfunction

    // Model: k counts consecutive enabled cycles; every output follows from k,
    // the captured ratio and the RX history of the current run.
    int   k = 0;
    int   p_m = 8;
    int   votes;
    int   base;
    logic sb_m = 1'b1;
    logic sv_m = 1'b0;
    logic bd_m = 1'b0;
    bit   armed = 1'b0;
    bit   hist [0:4095];
    logic log_bit [$];
    int   log_edge [$];

    always begin
        @(posedge CLK);
        if (RST) begin
            k = 0; p_m = 8; sb_m = 1'b1; sv_m = 1'b0; bd_m = 1'b0; armed = 1'b1;
        end else if (!dat_samp_en) begin
            k = 0; p_m = effP(Prescale); sv_m = 1'b0; bd_m = 1'b0;
        end else begin
            hist[k % 4096] = RX_IN;
            k++;
            bd_m = (k % p_m == 0);
            sv_m = (k % p_m == p_m / 2 + 2);
            if (sv_m) begin
                base  = k - (k % p_m) + p_m / 2;
                votes = int'(hist[(base - 2) % 4096]) + int'(hist[(base - 1) % 4096]) + int'(hist[base % 4096]);
                sb_m  = (votes >= 2);
            end
        end
        #1;
        if (armed) begin
            checkOutput("edge_cnt", 32'(edge_cnt), k % p_m);
            checkOutput("bit_cnt", 32'(bit_cnt), (k / p_m) % FRAME_BITS);
            checkOutput("bit_done", 32'(bit_done), 32'(bd_m));
            checkOutput("sample_valid", 32'(sample_valid), 32'(sv_m));
            checkOutput("sampled_bit", 32'(sampled_bit), 32'(sb_m));
            if (sample_valid === 1'b1) begin
                log_bit.push_back(sampled_bit);
                log_edge.push_back(int'(edge_cnt));
            end
        end
    end

    initial begin
        logic [10:0] frame;
        logic [5:0]  opts [8];
        logic [5:0]  ps_cur;
        logic        en_cur;
        logic        rx_cur;
        int          done_cnt;
        int          last_done;
        int          gap_bad;
        int          edge_bad;

        opts = '{6'd5, 6'd8, 6'd9, 6'd16, 6'd17, 6'd32, 6'd33, 6'd0};

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 6'd8);
        applyStimulus(1'b0, 1'b0, 1'b1, 6'd8);
        checkOutput("reset_edge_cnt", 32'(edge_cnt), 0);
        checkOutput("reset_bit_cnt", 32'(bit_cnt), 0);
        checkOutput("reset_sampled_bit", 32'(sampled_bit), 1);
        checkOutput("reset_pulses", {30'd0, bit_done, sample_valid}, 0);

        $display("[TB] P=8 frame 0x55");
        frame = {1'b1, 1'b0, 8'h55, 1'b0};
        log_bit.delete(); log_edge.delete();
        for (int b = 0; b < 11; b++)
            for (int e = 0; e < 8; e++) applyStimulus(1'b0, 1'b1, frame[b], 6'd8);
        checkOutput("frame_last_bit_cnt", 32'(bit_cnt), 10);
        checkOutput("frame_last_edge", 32'(edge_cnt), 7);
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd8);
        checkOutput("frame_wrap_bit_cnt", 32'(bit_cnt), 0);
        checkOutput("frame_wrap_bit_done", 32'(bit_done), 1);
        checkOutput("frame_sample_count", log_bit.size(), 11);
        for (int i = 0; i < 11 && i < log_bit.size(); i++) begin
            checkOutput("frame_sampled_bit", 32'(log_bit[i]), 32'(frame[i]));
            checkOutput("frame_sample_edge", log_edge[i], 6);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 6'd16);
        applyStimulus(1'b0, 1'b0, 1'b1, 6'd16);

        $display("[TB] P=16 glitch filtering");
        log_bit.delete(); log_edge.delete();
        for (int j = 0; j < 32; j++)
            applyStimulus(1'b0, 1'b1, !(j == 7 || j == 22 || j == 23), 6'd16);
        checkOutput("glitch_sample_count", log_bit.size(), 2);
        if (log_bit.size() == 2) begin
            checkOutput("glitch_single", 32'(log_bit[0]), 1);
            checkOutput("glitch_double", 32'(log_bit[1]), 0);
            checkOutput("glitch_edge0", log_edge[0], 10);
            checkOutput("glitch_edge1", log_edge[1], 10);
        end

        $display("[TB] prescale clamping and mid-frame change");
        for (int t = 0; t < 2; t++) begin
            ps_cur = (t == 0) ? 6'd5 : 6'd9;
            applyStimulus(1'b0, 1'b0, 1'b1, ps_cur);
            for (int j = 0; j < 8; j++) applyStimulus(1'b0, 1'b1, 1'b1, ps_cur);
            checkOutput("clamp_edge_max", 32'(edge_cnt), 7);
            applyStimulus(1'b0, 1'b1, 1'b1, ps_cur);
            checkOutput("clamp_wrap_edge", 32'(edge_cnt), 0);
            checkOutput("clamp_wrap_bit", 32'(bit_cnt), 1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 6'd8);
        for (int j = 0; j < 16; j++) applyStimulus(1'b0, 1'b1, 1'b1, (j < 3) ? 6'd8 : 6'd16);
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd16);
        checkOutput("midchange_edge", 32'(edge_cnt), 0);
        checkOutput("midchange_bit", 32'(bit_cnt), 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 6'd16);
        for (int j = 0; j < 9; j++) applyStimulus(1'b0, 1'b1, 1'b1, 6'd16);
        checkOutput("reenable_p16_edge", 32'(edge_cnt), 8);

        $display("[TB] deassert mid-bit");
        applyStimulus(1'b0, 1'b0, 1'b1, 6'd8);
        for (int j = 0; j < 35; j++) applyStimulus(1'b0, 1'b1, ((j / 8) % 2 == 1) ? 1'b0 : 1'b1, 6'd8);
        log_bit.delete(); log_edge.delete();
        applyStimulus(1'b0, 1'b0, 1'b0, 6'd8);
        checkOutput("deassert_at_edge", 32'(edge_cnt), 3);
        checkOutput("deassert_at_bit", 32'(bit_cnt), 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 6'd8);
        checkOutput("deassert_edge_clr", 32'(edge_cnt), 0);
        checkOutput("deassert_bit_clr", 32'(bit_cnt), 0);
        checkOutput("deassert_sampled_hold", 32'(sampled_bit), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 6'd8);
        checkOutput("deassert_no_valid", log_bit.size(), 0);

        $display("[TB] reset while enabled");
        for (int j = 0; j < 21; j++) applyStimulus(1'b0, 1'b1, 1'b0, 6'd8);
        applyStimulus(1'b1, 1'b1, 1'b0, 6'd8);
        checkOutput("rst_at_edge", 32'(edge_cnt), 5);
        checkOutput("rst_at_bit", 32'(bit_cnt), 2);
        checkOutput("rst_before_sampled", 32'(sampled_bit), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 6'd8);
        checkOutput("rst_edge", 32'(edge_cnt), 0);
        checkOutput("rst_bit", 32'(bit_cnt), 0);
        checkOutput("rst_sampled", 32'(sampled_bit), 1);
        checkOutput("rst_pulses", {30'd0, bit_done, sample_valid}, 0);
        for (int j = 0; j < 3; j++) applyStimulus(1'b0, 1'b1, 1'b0, 6'd8);
        checkOutput("rst_restart_edge", 32'(edge_cnt), 3);

        $display("[TB] P=32 full frame");
        applyStimulus(1'b0, 1'b0, 1'b1, 6'd32);
        log_bit.delete(); log_edge.delete();
        done_cnt = 0; last_done = 0; gap_bad = 0;
        for (int j = 0; j <= 352; j++) begin
            applyStimulus(1'b0, 1'b1, 1'($urandom), 6'd32);
            if (bit_done === 1'b1) begin
                if (done_cnt > 0 && j - last_done != 32) gap_bad++;
                last_done = j;
                done_cnt++;
            end
        end
        checkOutput("p32_done_count", done_cnt, 11);
        checkOutput("p32_done_gaps", gap_bad, 0);
        checkOutput("p32_wrap_bit", 32'(bit_cnt), 0);
        checkOutput("p32_valid_count", log_bit.size(), 11);
        edge_bad = 0;
        foreach (log_edge[i]) if (log_edge[i] != 18) edge_bad++;
        checkOutput("p32_valid_edges", edge_bad, 0);

        $display("[TB] randomized run");
        en_cur = 1'b0; ps_cur = 6'd8; rx_cur = 1'b1;
        for (int j = 0; j < 3000; j++) begin
            if ($urandom_range(0, 99) < 2) en_cur = ~en_cur;
            if ($urandom_range(0, 49) == 0) ps_cur = opts[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) == 0) rx_cur = ~rx_cur;
            applyStimulus($urandom_range(0, 299) == 0, en_cur, rx_cur, ps_cur);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 6'd8);
        applyStimulus(1'b0, 1'b0, 1'b1, 6'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
